// File: rtl/apuf_response_reader.sv
// -----------------------------------------------------------------------------
// apuf_response_reader
//
// This module sits at the far end of an arbiter-PUF delay line. It drives the
// line and collects one response bit per challenge:
//   - latches a challenge and holds it on the stage selects for the whole run
//   - holds the arbiter cleared for a setup window
//   - fires the launch edge NUM_EVAL times; each race is a settle window with
//     launch high followed by a relax window with the arbiter cleared
//   - samples the synchronised arbiter output on the last cycle of each settle
//     window and counts the ones
//   - majority-votes the count into one response bit and offers it on a
//     valid/ready handshake
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   start          evaluate challenge_in (accepted only while idle)
//   challenge_in   challenge captured on an accepted start
//   busy           high in every state except idle
//   challenge_out  registered stage selects to the delay line
//   launch         race launch edge into the delay line
//   arb_clr        holds the arbiter latch cleared
//   arb_out        asynchronous arbiter latch output
//   response       majority-voted response bit
//   ones_count     number of races that sampled 1 (reliability metric)
//   response_valid response and ones_count are valid
//   response_ready consumer accepts the result
// -----------------------------------------------------------------------------
module apuf_response_reader #(
  parameter int LINE_LENGTH   = 64,
  parameter int NUM_EVAL      = 15,
  parameter int SETUP_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RELAX_CYCLES  = 8,
  parameter int CNT_W         = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LINE_LENGTH-1:0] challenge_in,
  output logic                   busy,
  output logic [LINE_LENGTH-1:0] challenge_out,
  output logic                   launch,
  output logic                   arb_clr,
  input  logic                   arb_out,
  output logic                   response,
  output logic [CNT_W-1:0]       ones_count,
  output logic                   response_valid,
  input  logic                   response_ready
);

  // One cycle counter is shared by the three timed phases; size it for the
  // longest of them.
  localparam int MAX_CYC_A = (SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC   = (MAX_CYC_A > RELAX_CYCLES) ? MAX_CYC_A : RELAX_CYCLES;
  localparam int CYC_W     = $clog2(MAX_CYC + 1);
  localparam int EVAL_W    = $clog2(NUM_EVAL + 1);

  localparam logic [CYC_W-1:0]  SETUP_LAST  = CYC_W'(SETUP_CYCLES - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]  RELAX_LAST  = CYC_W'(RELAX_CYCLES - 1);
  localparam logic [EVAL_W-1:0] EVAL_TOTAL  = EVAL_W'(NUM_EVAL);
  localparam logic [CNT_W-1:0]  ONES_MAX    = {CNT_W{1'b1}};
  // Integer division: with an even NUM_EVAL a tie votes 0.
  localparam logic [CNT_W-1:0]  ONES_HALF   = CNT_W'(NUM_EVAL / 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RELAX  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e                 state_q,     state_d;
  logic [CYC_W-1:0]       cyc_q,       cyc_d;
  logic [EVAL_W-1:0]      eval_q,      eval_d;
  logic [CNT_W-1:0]       ones_q,      ones_d;
  logic                   resp_q,      resp_d;
  logic [LINE_LENGTH-1:0] chal_q,      chal_d;
  logic                   launch_q,    launch_d;
  logic                   arb_clr_q,   arb_clr_d;
  logic                   busy_q,      busy_d;
  logic                   valid_q,     valid_d;
  logic                   arb_meta_q,  arb_meta_d;
  logic                   arb_s_q,     arb_s_d;

  // ---------------------------------------------------------------------------
  // State register and all flops. Every output is a flop so the delay line and
  // the consumer see clean, glitch-free levels.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      eval_q     <= '0;
      ones_q     <= '0;
      resp_q     <= 1'b0;
      chal_q     <= '0;
      launch_q   <= 1'b0;
      arb_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      arb_meta_q <= 1'b0;
      arb_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      eval_q     <= eval_d;
      ones_q     <= ones_d;
      resp_q     <= resp_d;
      chal_q     <= chal_d;
      launch_q   <= launch_d;
      arb_clr_q  <= arb_clr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      arb_meta_q <= arb_meta_d;
      arb_s_q    <= arb_s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser on the asynchronous arbiter latch. The value used on
  // a sample cycle is therefore the one that was present two edges earlier;
  // the settle window must be long enough to cover this (SETTLE_CYCLES >= 3).
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_meta_d = arb_out;
    arb_s_d    = arb_meta_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CYC_W'(1);
    eval_d  = eval_q;
    ones_d  = ones_q;
    resp_d  = resp_q;
    chal_d  = chal_q;

    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (start) begin
          chal_d  = challenge_in;
          ones_d  = '0;
          eval_d  = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cyc_q == SETUP_LAST) begin
          cyc_d   = '0;
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (cyc_q == SETTLE_LAST) begin
          // Last settle cycle: the race has resolved, take the sample.
          if (arb_s_q && (ones_q != ONES_MAX)) begin
            ones_d = ones_q + CNT_W'(1);
          end
          // The race counter advances as the relax window is entered, so the
          // exit test of that window sees the number of races completed.
          eval_d  = eval_q + EVAL_W'(1);
          cyc_d   = '0;
          state_d = ST_RELAX;
        end
      end

      ST_RELAX: begin
        if (cyc_q == RELAX_LAST) begin
          cyc_d = '0;
          if (eval_q == EVAL_TOTAL) begin
            // All samples are already in ones_q; the last one was taken a
            // full relax window ago.
            resp_d  = (ones_q > ONES_HALF);
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end

      ST_DONE: begin
        cyc_d = '0;
        if (response_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        cyc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, registered. launch and arb_clr are
  // decoded from disjoint state sets, so they can never be high together.
  // ---------------------------------------------------------------------------
  always_comb begin
    launch_d  = (state_d == ST_LAUNCH);
    arb_clr_d = (state_d == ST_SETUP) || (state_d == ST_RELAX);
    busy_d    = (state_d != ST_IDLE);
    valid_d   = (state_d == ST_DONE);
  end

  assign busy           = busy_q;
  assign challenge_out  = chal_q;
  assign launch         = launch_q;
  assign arb_clr        = arb_clr_q;
  assign response       = resp_q;
  assign ones_count     = ones_q;
  assign response_valid = valid_q;

endmodule

// File: tb/tb_apuf_response_reader.sv
module tb_apuf_response_reader;

  localparam int LL   = 64;
  localparam int NE   = 15;
  localparam int SU   = 4;
  localparam int ST   = 8;
  localparam int RX   = 8;
  localparam int CW   = 5;
  localparam int PER  = ST + RX;
  localparam int LAT  = SU + NE * PER;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LL-1:0] challenge_in = '0;
  logic          busy;
  logic [LL-1:0] challenge_out;
  logic          launch;
  logic          arb_clr;
  logic          arb_out = 1'b0;
  logic          response;
  logic [CW-1:0] ones_count;
  logic          response_valid;
  logic          response_ready = 1'b0;

  always #5 clk = ~clk;

  apuf_response_reader #(
    .LINE_LENGTH  (LL),
    .NUM_EVAL     (NE),
    .SETUP_CYCLES (SU),
    .SETTLE_CYCLES(ST),
    .RELAX_CYCLES (RX),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .challenge_in  (challenge_in),
    .busy          (busy),
    .challenge_out (challenge_out),
    .launch        (launch),
    .arb_clr       (arb_clr),
    .arb_out       (arb_out),
    .response      (response),
    .ones_count    (ones_count),
    .response_valid(response_valid),
    .response_ready(response_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 running, 2 result offered.
  int            m_mode = 0;
  int            m_t    = 0;   // edges since the accepting edge
  int            m_ones = 0;
  logic          m_resp = 1'b0;
  logic [LL-1:0] m_chal = '0;
  logic          m_s1 = 1'b0;
  logic          m_s2 = 1'b0;

  // Stimulus control for the arbiter driver.
  int            arb_mode = 0;   // 0 pattern, 1 pattern + glitches off the sample slot, 2 random
  logic [NE-1:0] pat = '0;       // bit r = arbiter level presented for race r

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: timeline of a run expressed as edge count since acceptance.
  // Race r samples at edge SU + r*PER + ST, using arb_out as it stood two edges
  // earlier.
  // ---------------------------------------------------------------------------
  initial begin
    logic samp;
    int   k;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_t = 0; m_ones = 0; m_resp = 1'b0; m_chal = '0;
        m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = arb_out;
        case (m_mode)
          0: if (start) begin
            m_mode = 1; m_t = 0; m_ones = 0; m_chal = challenge_in;
          end
          1: begin
            k = m_t + 1;
            if (k > SU && ((k - SU) % PER) == ST && samp && m_ones < (1 << CW) - 1)
              m_ones++;
            m_t = k;
            if (k == LAT) begin
              m_mode = 2;
              m_resp = (m_ones > NE / 2);
            end
          end
          default: if (response_ready) m_mode = 0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter driver: changes arb_out on falling edges only.
  // ---------------------------------------------------------------------------
  initial begin
    int   p, r, o;
    logic v;
    forever begin
      @(negedge clk);
      if (arb_mode == 2) begin
        arb_out = 1'($urandom_range(0, 1));
      end else begin
        p = m_t + 1;
        if (m_mode == 1 && p > SU) begin
          r = (p - SU - 1) / PER;
          o = (p - SU - 1) % PER;
          v = pat[r];
          // Slot ST-3 of a race is the one that reaches the sample edge.
          if (arb_mode == 1 && o != ST - 3) v = 1'($urandom_range(0, 1));
        end else begin
          v = pat[0];
        end
        arb_out = v;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One run: start, waveform measurement, result, backpressure, handshake.
  // ---------------------------------------------------------------------------
  task automatic do_run(input logic [63:0] c, input int amode, input logic [NE-1:0] p,
                        input int stall, input bit early_ready, input bit same_start,
                        input int exp_ones, input int exp_resp, input string tag);
    int   cyc, pulses, hi_len, lo_len, hmin, hmax, gmin, gmax, setup_len, clr_bad, unstable;
    logic prev_l, r0;
    logic [CW-1:0] o0;
    arb_mode = amode;
    pat = p;
    pulses = 0; hi_len = 0; lo_len = 0; hmin = 999; hmax = 0; gmin = 999; gmax = 0;
    setup_len = 0; clr_bad = 0; unstable = 0; prev_l = 1'b0;
    response_ready = early_ready;
    @(negedge clk);
    start = 1'b1;
    challenge_in = c;
    @(negedge clk);
    start = 1'b0;
    challenge_in = {$urandom, $urandom};
    chk("chal_latched", 64'(challenge_out), c);
    cyc = 1;
    while (response_valid !== 1'b1 && cyc < 400) begin
      if (launch) begin
        if (!prev_l) begin
          pulses++;
          if (pulses == 1) setup_len = lo_len;
          else begin
            if (lo_len < gmin) gmin = lo_len;
            if (lo_len > gmax) gmax = lo_len;
          end
          hi_len = 0;
        end
        hi_len++;
      end else begin
        if (prev_l) begin
          if (hi_len < hmin) hmin = hi_len;
          if (hi_len > hmax) hmax = hi_len;
        end
        lo_len = prev_l ? 1 : lo_len + 1;
        if (!arb_clr) clr_bad++;
      end
      prev_l = launch;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc - 1), 64'(LAT));
    chk("pulse_count", 64'(pulses), 64'(NE));
    chk("pulse_min", 64'(hmin), 64'(ST));
    chk("pulse_max", 64'(hmax), 64'(ST));
    chk("gap_min", 64'(gmin), 64'(RX));
    chk("gap_max", 64'(gmax), 64'(RX));
    chk("setup_len", 64'(setup_len), 64'(SU));
    chk("low_without_clr", 64'(clr_bad), 64'd0);
    if (exp_ones >= 0) begin
      chk("ones_lit", 64'(ones_count), 64'(exp_ones));
      chk("resp_lit", 64'(response), 64'(exp_resp));
    end
    r0 = response;
    o0 = ones_count;
    $display("run %s: chal=%h ones=%0d resp=%0d latency=%0d stall=%0d", tag, c, ones_count,
             response, cyc - 1, stall);
    if (!early_ready) begin
      repeat (stall) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (response_valid !== 1'b1 || response !== r0 || ones_count !== o0) unstable++;
      end
      chk("stall_stable", 64'(unstable), 64'd0);
      start = same_start;
      response_ready = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("valid_drop", 64'(response_valid), 64'd0);
    chk("busy_drop", 64'(busy), 64'd0);
    response_ready = 1'b0;
    @(negedge clk);
    chk("stay_idle", 64'(busy), 64'd0);
    chk("result_kept", 64'(ones_count), 64'(o0));
  endtask

  initial begin
    logic [NE-1:0] rp;
    int            w;
    fork
      // Per-cycle compare against the model.
      begin
        int   pp, oo;
        logic e_busy, e_launch, e_clr, e_valid;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_launch", 64'(launch), 64'd0);
            chk("rst_clr", 64'(arb_clr), 64'd0);
            chk("rst_valid", 64'(response_valid), 64'd0);
            chk("rst_resp", 64'(response), 64'd0);
            chk("rst_ones", 64'(ones_count), 64'd0);
            chk("rst_chal", 64'(challenge_out), 64'd0);
          end else begin
            e_busy = (m_mode != 0);
            e_valid = (m_mode == 2);
            e_launch = 1'b0;
            e_clr = 1'b0;
            if (m_mode == 1) begin
              pp = m_t + 1;
              if (pp <= SU) e_clr = 1'b1;
              else begin
                oo = (pp - SU - 1) % PER;
                if (oo < ST) e_launch = 1'b1;
                else e_clr = 1'b1;
              end
            end
            chk("busy", 64'(busy), 64'(e_busy));
            chk("valid", 64'(response_valid), 64'(e_valid));
            chk("launch", 64'(launch), 64'(e_launch));
            chk("arb_clr", 64'(arb_clr), 64'(e_clr));
            chk("challenge_out", 64'(challenge_out), 64'(m_chal));
            chk("ones_count", 64'(ones_count), 64'(m_ones));
            if (e_valid) chk("response", 64'(response), 64'(m_resp));
            chk("launch_and_clr", 64'(launch & arb_clr), 64'd0);
          end
        end
      end
      // Directed and random runs.
      begin
        repeat (3) @(negedge clk);
        chk("reset_chal", 64'(challenge_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(64'hA5A5_0000_FFFF_1234, 0, 15'h7FFF, 0, 1'b0, 1'b0, 15, 1, "forced1");
        do_run(64'h0123_4567_89AB_CDEF, 1, 15'h00FF, 20, 1'b0, 1'b0, 8, 1, "races1to8");
        do_run(64'hFEDC_BA98_7654_3210, 1, 15'h007F, 3, 1'b0, 1'b1, 7, 0, "races1to7");
        rp = NE'($urandom);
        do_run({$urandom, $urandom}, 1, rp, 0, 1'b1, 1'b0, $countones(rp),
               ($countones(rp) > 7) ? 1 : 0, "ready_held");

        // Reset during race 6: five races already sampled with arb_out=1.
        arb_mode = 0;
        pat = 15'h7FFF;
        @(negedge clk);
        start = 1'b1;
        challenge_in = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(m_mode == 1 && m_t + 1 >= SU + 5 * PER + 3) && w < 400) begin
          @(negedge clk);
          w++;
        end
        chk("reach_race6", 64'(w < 400), 64'd1);
        chk("ones_before_rst", 64'(ones_count), 64'd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_launch", 64'(launch), 64'd0);
        chk("async_clr", 64'(arb_clr), 64'd0);
        chk("async_ones", 64'(ones_count), 64'd0);
        chk("async_chal", 64'(challenge_out), 64'd0);
        chk("async_valid", 64'(response_valid), 64'd0);
        $display("run midreset: reset asserted at edge %0d of run", w);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_run(64'h1111_2222_3333_4444, 0, 15'h5555, 2, 1'b0, 1'b0, 8, 1, "after_reset");

        for (int i = 0; i < 4; i++) begin
          do_run({$urandom, $urandom}, 2, '0, $urandom_range(0, 6), 1'b0,
                 1'($urandom_range(0, 1)), -1, 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join
  end

endmodule

// File: doc/apuf_response_reader.md
Name: apuf_response_reader

Overview:
- Controller and capture stage on the far end of the arbiter-PUF delay line.
- Latches a challenge and drives it onto the delay line's stage selects.
- Fires the launch edge NUM_EVAL times and samples the arbiter latch output after each race.
- Majority-votes the samples into one response bit and hands it off on a valid/ready interface.

Parameters:
- LINE_LENGTH, 64, number of delay-line stages (challenge width)
- NUM_EVAL, 15, races per challenge; must be odd and ≥1
- SETUP_CYCLES, 4, cycles the challenge is held stable before the first launch
- SETTLE_CYCLES, 8, cycles launch is held high per race; must be ≥3
- RELAX_CYCLES, 8, cycles launch is held low (arbiter cleared) between races
- CNT_W, 5, ones-counter width; ≥ clog2(NUM_EVAL+1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to evaluate challenge_in; accepted only in IDLE
- challenge_in  in  LINE_LENGTH  challenge captured on accepted start
- busy  out  1  high in every state except IDLE
- challenge_out  out  LINE_LENGTH  registered stage selects to the delay line
- launch  out  1  race launch edge into the delay line
- arb_clr  out  1  clears the arbiter latch
- arb_out  in  1  asynchronous arbiter latch output
- response  out  1  majority-voted response bit
- ones_count  out  CNT_W  number of races that sampled 1 (reliability metric)
- response_valid  out  1  response and ones_count valid
- response_ready  in  1  consumer accepts the result

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all outputs 0, including challenge_out, counters and both synchroniser flops.
- arb_out passes through a 2-flop synchroniser (arb_s) before use.
- FSM states: IDLE, SETUP, LAUNCH, RELAX, DONE.
- IDLE:
  - On start=1, latch challenge_in into challenge_out, clear ones_count and the eval counter, go to SETUP.
  - start is ignored in every other state.
- SETUP:
  - launch=0, arb_clr=1 for SETUP_CYCLES cycles, then go to LAUNCH.
- LAUNCH:
  - launch=1, arb_clr=0 for SETTLE_CYCLES cycles.
  - On the last LAUNCH cycle, arb_s is sampled and ones_count increments if arb_s=1.
  - Saturate ones_count at 2^CNT_W-1; this cannot occur with legal parameters.
  - Then go to RELAX.
- RELAX:
  - launch=0, arb_clr=1 for RELAX_CYCLES cycles.
  - The eval counter increments on RELAX entry.
  - On exit, go to DONE if the eval counter equals NUM_EVAL, otherwise go to LAUNCH.
- DONE:
  - response_valid=1; response = (ones_count > NUM_EVAL/2) using integer division, so a tie with an illegal even NUM_EVAL yields 0.
  - response, ones_count and challenge_out are held stable while valid.
  - On response_valid & response_ready, go to IDLE on the next edge and drop response_valid.
  - response and ones_count keep their values until the next accepted start.
- Latency:
  - response_valid rises exactly SETUP_CYCLES + NUM_EVAL*(SETTLE_CYCLES+RELAX_CYCLES) cycles after the edge that accepted start.
  - With defaults this is 4 + 15*16 = 244 cycles.
- Cycle boundaries:
  - response_ready held high in DONE gives a single-cycle valid pulse; busy then drops on the following cycle.
  - start asserted in the same cycle that DONE is left is ignored; the earliest acceptance is the first cycle busy=0.
- Reset mid-evaluation: immediate return to IDLE with all outputs 0; no partial result is ever presented.
- launch and arb_clr are never high in the same cycle.

Test Plan:
- Forced value 1: arb_out held 1, start with challenge 64'hA5A5_0000_FFFF_1234 → challenge_out matches from the cycle after start; valid at cycle 244; response=1, ones_count=15.
- Mixed samples: arb_out=1 during races 1-8 and 0 during races 9-15 → ones_count=8, response=1. Repeat with races 1-7 =1 → ones_count=7, response=0.
- Waveform check: count launch pulses (15, each 8 cycles high) and the gaps between them (8 cycles, arb_clr=1). launch and arb_clr are never both 1; SETUP is 4 cycles with launch=0.
- Backpressure: response_ready=0 for 20 cycles in DONE → valid, response and ones_count stable; start pulses during the stall are ignored. Raise ready → valid drops next cycle, busy=0.
- Mid-run reset: rst_n=0 during race 6 → all outputs 0 asynchronously (before the next edge). A new start after release yields a full 244-cycle run with fresh counts.
- Synchroniser: arb_out toggles 1 cycle before the sample point → the sample reflects the value 2 cycles earlier; ones_count is unaffected by glitches outside the sample cycle.
